pe_window_feeder: RTL and testbench

//   Producer side of the PE operand interface. Streams 3x3 convolution windows into one PE as

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_window_counter.sv | 83 ++++++++
 rtl/pe_window_feeder.sv | 134 +++++++++++++
 tb/tb_pe_window_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, feeder state encoding and tap-offset helpers for the PE window feeder.
package pe_pkg;

  localparam int KERNEL     = 3;
  localparam int TAPS       = KERNEL * KERNEL;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  // Row/column offset of tap k inside the 3x3 window, row-major.
  function automatic logic [1:0] tap_row(input logic [3:0] k);
    return 2'(k / 4'(KERNEL));
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] k);
    return 2'(k % 4'(KERNEL));
  endfunction

endpackage

// File: rtl/pe_window_counter.sv
// Tap/column/row counters for the window sweep, producing pixel coordinates and wrap flags.
// With PE_FEEDER_PAD_EN defined the origin sweeps one extra pixel on each side and in_bounds is emitted.
module pe_window_counter
  import pe_pkg::*;
#(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int CW    = $clog2(IMG_W + 2),
  parameter int RW    = $clog2(IMG_H + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [3:0]    k,
  output logic [CW-1:0] pix_col,
  output logic [RW-1:0] pix_row,
  output logic          tap_last,
`ifdef PE_FEEDER_PAD_EN
  output logic          in_bounds,
`endif
  output logic          pass_last
);

`ifdef PE_FEEDER_PAD_EN
  localparam int NC = IMG_W;
  localparam int NR = IMG_H;
`else
  localparam int NC = IMG_W - 2;
  localparam int NR = IMG_H - 2;
`endif

  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          col_last;
  logic          row_last;

  assign tap_last  = (k == 4'(TAPS - 1));
  assign col_last  = (c == CW'(NC - 1));
  assign row_last  = (r == RW'(NR - 1));
  assign pass_last = tap_last & col_last & row_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0;
      c <= '0;
      r <= '0;
    end else if (clear) begin
      k <= '0;
      c <= '0;
      r <= '0;
    end else if (advance) begin
      if (tap_last) begin
        k <= '0;
        if (col_last) begin
          c <= '0;
          r <= row_last ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end else begin
        k <= k + 4'd1;
      end
    end
  end

`ifdef PE_FEEDER_PAD_EN
  // Padded coordinates are offset by +1 so the -1 origin stays unsigned.
  logic [CW-1:0] col_p;
  logic [RW-1:0] row_p;

  assign col_p     = c + CW'(tap_col(k));
  assign row_p     = r + RW'(tap_row(k));
  assign in_bounds = (col_p >= CW'(1)) && (col_p <= CW'(IMG_W)) &&
                     (row_p >= RW'(1)) && (row_p <= RW'(IMG_H));
  assign pix_col   = col_p - CW'(1);
  assign pix_row   = row_p - RW'(1);
`else
  assign pix_col = c + CW'(tap_col(k));
  assign pix_row = r + RW'(tap_row(k));
`endif

endmodule

// File: rtl/pe_window_feeder.sv
// Streams 3x3 windows of an image buffer into one PE as aligned pixel/weight pairs, nine per output.
// Define PE_FEEDER_PAD_EN for "same" convolution with 1-pixel zero padding.
module pe_window_feeder
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flt_wr_en,
  input  logic [3:0]        flt_wr_idx,
  input  logic [DATA_W-1:0] flt_wr_data,
  input  logic              start,
  output logic [ADDR_W-1:0] img_addr,
  output logic              img_rd_en,
  input  logic [DATA_W-1:0] img_rdata,
  output logic [DATA_W-1:0] pe_in,
  output logic [DATA_W-1:0] pe_filter,
  output logic              feed_valid,
  output logic              window_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);

  feeder_state_t state, state_next;
  logic              drain_cnt;
  logic [DATA_W-1:0] filter [TAPS];

  logic              run;
  logic              accept;
  logic [3:0]        k;
  logic [CW-1:0]     pix_col;
  logic [RW-1:0]     pix_row;
  logic              tap_last;
  logic              pass_last;
  logic              in_bounds;

  logic              v1;
  logic              last1;
  logic              inb1;
  logic [DATA_W-1:0] w1;

  assign run    = (state == RUN);
  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  pe_window_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .advance   (run),
    .k         (k),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .tap_last  (tap_last),
`ifdef PE_FEEDER_PAD_EN
    .in_bounds (in_bounds),
`endif
    .pass_last (pass_last)
  );

`ifndef PE_FEEDER_PAD_EN
  assign in_bounds = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pass_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weights only change between passes so a pass always sees one consistent filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) filter[i] <= '0;
    end else if ((state == IDLE) && flt_wr_en && (flt_wr_idx < 4'(TAPS))) begin
      filter[flt_wr_idx] <= flt_wr_data;
    end
  end

  assign img_rd_en = run & in_bounds;
  assign img_addr  = img_rd_en ? (ADDR_W'(pix_row) * ADDR_W'(IMG_W) + ADDR_W'(pix_col)) : '0;

  // Two-stage pipe: stage 1 waits for the buffer's read latency, stage 2 registers the PE operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1          <= 1'b0;
      last1       <= 1'b0;
      inb1        <= 1'b0;
      w1          <= '0;
      pe_in       <= '0;
      pe_filter   <= '0;
      feed_valid  <= 1'b0;
      window_last <= 1'b0;
    end else begin
      v1          <= run;
      last1       <= run & tap_last;
      inb1        <= run & in_bounds;
      w1          <= run ? filter[k] : '0;
      pe_in       <= inb1 ? img_rdata : '0;
      pe_filter   <= v1 ? w1 : '0;
      feed_valid  <= v1;
      window_last <= last1;
    end
  end

endmodule

// File: tb/tb_pe_window_feeder.sv
// Randomized self-checking bench for pe_window_feeder against a window-sweep reference model.
// Follows PE_FEEDER_PAD_EN to select "same" or "valid" expectations.
module tb_pe_window_feeder;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int ADDR_W = 8;
`ifdef PE_FEEDER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int NWC   = IMG_W - 2 + 2 * PAD;
  localparam int NWR   = IMG_H - 2 + 2 * PAD;
  localparam int NTAPS = 9 * NWC * NWR;

  logic              clk;
  logic              rst;
  logic              flt_wr_en;
  logic [3:0]        flt_wr_idx;
  logic [DATA_W-1:0] flt_wr_data;
  logic              start;
  logic [ADDR_W-1:0] img_addr;
  logic              img_rd_en;
  logic [DATA_W-1:0] img_rdata;
  logic [DATA_W-1:0] pe_in;
  logic [DATA_W-1:0] pe_filter;
  logic              feed_valid;
  logic              window_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] img_mem [256];
  logic [DATA_W-1:0] flt_model [9];
  int checks = 0;
  int errors = 0;

  pe_window_feeder #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flt_wr_en   (flt_wr_en),
    .flt_wr_idx  (flt_wr_idx),
    .flt_wr_data (flt_wr_data),
    .start       (start),
    .img_addr    (img_addr),
    .img_rd_en   (img_rd_en),
    .img_rdata   (img_rdata),
    .pe_in       (pe_in),
    .pe_filter   (pe_filter),
    .feed_valid  (feed_valid),
    .window_last (window_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= img_mem[img_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Tap t of the pass: window t/9 in row-major origin order, offset (t%9)/3, (t%9)%3.
  task automatic expectedTap(input int t, output logic [7:0] px, output logic [7:0] wt,
                             output logic lst, output logic inb, output logic [7:0] ad);
    int w, kk, pr, pc;
    w   = t / 9;
    kk  = t % 9;
    pr  = (w / NWC) - PAD + kk / 3;
    pc  = (w % NWC) - PAD + kk % 3;
    inb = (pr >= 0) && (pr < IMG_H) && (pc >= 0) && (pc < IMG_W);
    ad  = inb ? 8'(pr * IMG_W + pc) : 8'd0;
    px  = inb ? img_mem[pr * IMG_W + pc] : 8'd0;
    wt  = flt_model[kk];
    lst = (kk == 8);
  endtask

  task automatic loadFilter(input int mode);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      flt_wr_en   = 1'b1;
      flt_wr_idx  = 4'(i);
      flt_wr_data = (mode == 0) ? 8'd1 : (mode == 1) ? 8'(i + 1) : 8'($urandom_range(0, 255));
      flt_model[i] = flt_wr_data;
    end
    @(negedge clk);
    flt_wr_idx  = 4'd12;
    flt_wr_data = 8'h5A;
    @(negedge clk);
    flt_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int abort_at, input int same_cycle_wt, input bit poke);
    int cyc, fed, iss, first_cyc, last_cyc, done_cyc;
    bit gap;
    logic [7:0] px, wt, ad;
    logic lst, inb;
    @(negedge clk);
    start = 1'b1;
    if (same_cycle_wt >= 0) begin
      flt_wr_en    = 1'b1;
      flt_wr_idx   = 4'd8;
      flt_wr_data  = 8'(same_cycle_wt);
      flt_model[8] = 8'(same_cycle_wt);
    end
    @(negedge clk);
    start     = 1'b0;
    flt_wr_en = 1'b0;
    cyc = 0; fed = 0; iss = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; gap = 1'b0;
    while (done_cyc < 0 && cyc < NTAPS + 20) begin
      if (iss < NTAPS) begin
        expectedTap(iss, px, wt, lst, inb, ad);
        checkOutput("img_rd_en", 32'(img_rd_en), 32'(inb));
        if (inb) checkOutput("img_addr", 32'(img_addr), 32'(ad));
        iss++;
      end
      if (feed_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        else if (last_cyc != cyc - 1) gap = 1'b1;
        last_cyc = cyc;
        expectedTap(fed, px, wt, lst, inb, ad);
        checkOutput("pe_in", 32'(pe_in), 32'(px));
        checkOutput("pe_filter", 32'(pe_filter), 32'(wt));
        checkOutput("window_last", 32'(window_last), 32'(lst));
        if (fed == abort_at) begin
          rst = 1'b0;
          #1;
          checkOutput("reset_mid_pass",
                      32'({pe_in, pe_filter, feed_valid, window_last, busy, done, img_rd_en, img_addr}), 32'd0);
          for (int i = 0; i < 9; i++) flt_model[i] = 8'd0;
          return;
        end
        fed++;
      end else begin
        checkOutput("idle_operands_zero", 32'({pe_in, pe_filter, window_last}), 32'd0);
      end
      if (done) done_cyc = cyc;
      checkOutput("busy", 32'(busy), 32'd1);
      if (poke) begin
        start       = (cyc == 30);
        flt_wr_en   = (cyc == 30);
        flt_wr_idx  = 4'd0;
        flt_wr_data = 8'hAA;
      end
      cyc++;
      @(negedge clk);
    end
    start     = 1'b0;
    flt_wr_en = 1'b0;
    checkOutput("tap_count", 32'(fed), 32'(NTAPS));
    checkOutput("first_tap_latency", 32'(first_cyc), 32'd2);
    checkOutput("contiguous", 32'(gap), 32'd0);
    checkOutput("done_timing", 32'(done_cyc), 32'(last_cyc + 1));
    checkOutput("idle_after_done", 32'({busy, done, feed_valid}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flt_wr_en = 1'b0; flt_wr_idx = '0; flt_wr_data = '0;
    for (int i = 0; i < 9; i++) flt_model[i] = 8'd0;
    for (int a = 0; a < 256; a++) img_mem[a] = (a < IMG_W * IMG_H) ? 8'(a + 1) : 8'd0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start       = 1'($urandom_range(0, 1));
      flt_wr_en   = 1'($urandom_range(0, 1));
      flt_wr_idx  = 4'($urandom_range(0, 15));
      flt_wr_data = 8'($urandom_range(0, 255));
      #1;
      checkOutput("reset_outputs",
                  32'({pe_in, pe_filter, feed_valid, window_last, busy, done, img_rd_en, img_addr}), 32'd0);
    end
    @(negedge clk);
    start = 1'b0; flt_wr_en = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_after_reset", 32'({pe_in, pe_filter, feed_valid, busy}), 32'd0);
    end

    $display("[TB] ramp image, unit filter");
    loadFilter(0);
    applyStimulus(-1, -1, 1'b0);

    $display("[TB] filter 1..9 with start/write pokes mid-pass");
    loadFilter(1);
    applyStimulus(-1, -1, 1'b1);

    $display("[TB] random image and filter, write coinciding with start");
    for (int a = 0; a < IMG_W * IMG_H; a++) img_mem[a] = 8'($urandom_range(0, 255));
    loadFilter(2);
    applyStimulus(-1, int'($urandom_range(1, 255)), 1'b0);

    $display("[TB] reset at tap 4 of window 2, then replay");
    applyStimulus(22, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(-1, -1, 1'b0);
    loadFilter(2);
    applyStimulus(-1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
